// File: rtl/data_mem_if.sv
// Load/store port between the processor's memory stage and its data memory.
// One request channel, one response channel, each with a valid/ready handshake.
interface data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Byte-addressed little-endian data memory with a fixed access latency.
// It services one load or store at a time over the data_mem_if handshake.
module data_mem_responder #(
  parameter int DEPTH_BYTES = 512,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  data_mem_if.slave   bus,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [7:0]      mem [DEPTH_BYTES];

  logic            lat_we;
  logic [1:0]      lat_size;
  logic            lat_unsigned;
  logic [63:0]     lat_addr;
  logic [63:0]     lat_wdata;

  logic            accept;
  logic            enter_resp;
  logic            acc_we;
  logic [1:0]      acc_size;
  logic            acc_unsigned;
  logic [63:0]     acc_addr;
  logic [63:0]     acc_wdata;
  logic [3:0]      nbytes;
  logic [64:0]     acc_end;
  logic            acc_err;
  logic [AW-1:0]   base;
  logic [63:0]     raw;
  logic [63:0]     ext;

  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves a signal unassigned would infer a latch.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    busy          = 1'b1;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        busy          = 1'b0;
        if (bus.req_valid) begin
          if (LATENCY == 1) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = CW'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_next = cnt - CW'(1);
        if (cnt == CW'(1)) state_next = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept     = bus.req_valid && (state == IDLE);
  assign enter_resp = (state_next == RESP) && (state != RESP);

  // With LATENCY=1 the access happens on the accept edge itself, before the
  // latched copy exists, so the live request fields are used while in IDLE.
  assign acc_we       = (state == IDLE) ? bus.req_we       : lat_we;
  assign acc_size     = (state == IDLE) ? bus.req_size     : lat_size;
  assign acc_unsigned = (state == IDLE) ? bus.req_unsigned : lat_unsigned;
  assign acc_addr     = (state == IDLE) ? bus.req_addr     : lat_addr;
  assign acc_wdata    = (state == IDLE) ? bus.req_wdata    : lat_wdata;

  assign nbytes  = 4'd1 << acc_size;
  assign acc_end = {1'b0, acc_addr} + 65'(nbytes);
  assign acc_err = ((acc_addr[2:0] & 3'(nbytes - 4'd1)) != 3'd0) ||
                   (acc_end > 65'(DEPTH_BYTES));
  assign base    = acc_addr[AW-1:0];

  always_comb begin
    raw = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < nbytes) raw[8*i +: 8] = mem[base + AW'(i)];
    end
  end

  always_comb begin
    ext = raw;
    case (acc_size)
      2'd0:    ext = acc_unsigned ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
      2'd1:    ext = acc_unsigned ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      2'd2:    ext = acc_unsigned ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: ext = raw;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the values from before the edge, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_we       <= 1'b0;
      lat_size     <= 2'd0;
      lat_unsigned <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
    end else if (accept) begin
      lat_we       <= bus.req_we;
      lat_size     <= bus.req_size;
      lat_unsigned <= bus.req_unsigned;
      lat_addr     <= bus.req_addr;
      lat_wdata    <= bus.req_wdata;
    end
  end

  // NOTE: the storage is built from resettable flops because reset must
  // leave every byte zero; a RAM macro without a clear port cannot do that.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_BYTES; i++) mem[i] <= 8'd0;
    end else if (enter_resp && acc_we && !acc_err) begin
      for (int i = 0; i < 8; i++) begin
        if (4'(i) < nbytes) mem[base + AW'(i)] <= acc_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else if (enter_resp) begin
      bus.rsp_rdata <= (acc_we || acc_err) ? 64'd0 : ext;
      bus.rsp_err   <= acc_err;
    end else if ((state == RESP) && bus.rsp_ready) begin
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end
  end

endmodule
